// File: rtl/bitscan_pkg.sv
// rtl/bitscan_pkg.sv - shared op encoding, per-slice scan record and scan helpers for bitscan_pipe
package bitscan_pkg;

  typedef enum logic [1:0] {
    POPCNT    = 2'd0,
    LAST_IDX  = 2'd1,
    CONT_ONE  = 2'd2,
    FIRST_IDX = 2'd3
  } bitscan_op_t;

  localparam int MAX_W   = 256;
  localparam int SLICE_W = $clog2(MAX_W + 1);

  typedef logic [SLICE_W-1:0] slice_cnt_t;

  typedef struct packed {
    slice_cnt_t cnt;
    slice_cnt_t hi;
    slice_cnt_t lo;
    slice_cnt_t tr;
    logic       all1;
  } slice_info_t;

  // Helpers take a zero-extended operand; the zero padding never changes any result.
  function automatic slice_cnt_t scan_popcnt(input logic [MAX_W-1:0] v);
    slice_cnt_t r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) r = r + SLICE_W'(v[i]);
    return r;
  endfunction

  function automatic slice_cnt_t scan_last_idx(input logic [MAX_W-1:0] v);
    slice_cnt_t r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) if (v[i]) r = SLICE_W'(i + 1);
    return r;
  endfunction

  function automatic slice_cnt_t scan_first_idx(input logic [MAX_W-1:0] v);
    slice_cnt_t r;
    r = '0;
    for (int i = MAX_W - 1; i >= 0; i--) if (v[i]) r = SLICE_W'(i + 1);
    return r;
  endfunction

  function automatic slice_cnt_t scan_cont_one(input logic [MAX_W-1:0] v);
    slice_cnt_t r;
    logic       run;
    r   = '0;
    run = 1'b1;
    for (int i = 0; i < MAX_W; i++) begin
      run = run & v[i];
      r   = r + SLICE_W'(run);
    end
    return r;
  endfunction

endpackage

// File: rtl/bitscan_chunk.sv
// rtl/bitscan_chunk.sv - combinational scan of one CHUNK-bit slice into a slice_info_t record
module bitscan_chunk
  import bitscan_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] data,
  output slice_info_t      info
);

  logic [MAX_W-1:0] ext;

  always_comb begin
    ext              = '0;
    ext[CHUNK-1:0]   = data;
    info.cnt         = scan_popcnt(ext);
    info.hi          = scan_last_idx(ext);
    info.lo          = scan_first_idx(ext);
    info.tr          = scan_cont_one(ext);
    info.all1        = (info.tr == SLICE_W'(CHUNK));
  end

endmodule

// File: rtl/bitscan_pipe.sv
// rtl/bitscan_pipe.sv - two-stage valid/ready bit-scan unit; BITSCAN_PIPE_TAG_EN adds a request tag
module bitscan_pipe
  import bitscan_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  CHUNK = 8,
  parameter int  TAG_W = 4,
  localparam int RES_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [RES_W-1:0] o_result,
`ifdef BITSCAN_PIPE_TAG_EN
  input  logic [TAG_W-1:0] i_tag,
  output logic [TAG_W-1:0] o_tag,
`endif
  output logic             o_zero
);

  localparam int NS = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0 || WIDTH > MAX_W || CHUNK < 2 || TAG_W < 1) begin : g_bad_param
    $error("bitscan_pipe: illegal WIDTH/CHUNK/TAG_W combination");
  end

  slice_info_t c_info [NS];
  slice_info_t s1_info [NS];
  bitscan_op_t s1_op;
  logic        s1_zero;
  logic        s1_valid;
  logic        s2_valid;
  logic        s2_adv;
  logic        s1_adv;
  logic        accept;
  logic [RES_W-1:0] comb_res;

  for (genvar g = 0; g < NS; g++) begin : g_chunk
    bitscan_chunk #(.CHUNK(CHUNK)) u_chunk (
      .data (i_data[g*CHUNK +: CHUNK]),
      .info (c_info[g])
    );
  end

  assign s2_adv  = !s2_valid || i_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign o_ready = s1_adv && !i_flush;
  assign o_valid = s2_valid;
  assign accept  = i_valid && o_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (i_flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= i_valid;
      if (s2_adv) s2_valid <= s1_valid;
    end
  end

  // Stage-1 payload is only meaningful under s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NS; k++) s1_info[k] <= c_info[k];
      s1_op   <= bitscan_op_t'(i_op);
      s1_zero <= (i_data == '0);
    end
  end

  always_comb begin
    logic [RES_W-1:0] sum;
    logic [RES_W-1:0] last;
    logic [RES_W-1:0] first;
    logic [RES_W-1:0] cont;
    logic             found;
    sum   = '0;
    last  = '0;
    first = '0;
    cont  = RES_W'(WIDTH);
    found = 1'b0;
    for (int k = 0; k < NS; k++) begin
      sum = sum + RES_W'(s1_info[k].cnt);
      if (s1_info[k].hi != '0) last = RES_W'(k * CHUNK) + RES_W'(s1_info[k].hi);
      if (!found && !s1_info[k].all1) begin
        cont  = RES_W'(k * CHUNK) + RES_W'(s1_info[k].tr);
        found = 1'b1;
      end
    end
    for (int k = NS - 1; k >= 0; k--) begin
      if (s1_info[k].lo != '0) first = RES_W'(k * CHUNK) + RES_W'(s1_info[k].lo);
    end
    case (s1_op)
      POPCNT:    comb_res = sum;
      LAST_IDX:  comb_res = last;
      CONT_ONE:  comb_res = cont;
      FIRST_IDX: comb_res = first;
      default:   comb_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_result <= '0;
      o_zero   <= 1'b0;
    end else if (!i_flush && s2_adv && s1_valid) begin
      o_result <= comb_res;
      o_zero   <= s1_zero;
    end
  end

`ifdef BITSCAN_PIPE_TAG_EN
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (accept) s1_tag <= i_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst) o_tag <= '0;
    else if (!i_flush && s2_adv && s1_valid) o_tag <= s1_tag;
  end
`endif

endmodule

// File: tb/tb_bitscan_pipe.sv
// tb/tb_bitscan_pipe.sv - self-checking bench for bitscan_pipe against a behavioural scan model
module tb_bitscan_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [5:0]  o_result;
  logic        o_zero;
`ifdef BITSCAN_PIPE_TAG_EN
  logic [3:0]  i_tag;
  logic [3:0]  o_tag;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] res;
    logic       zero;
    logic [3:0] tag;
  } exp_t;

  exp_t       q[$];
  logic       hold_pend = 1'b0;
  logic [5:0] hold_res;
  logic       hold_zero;
  logic [3:0] hold_tag;

  bitscan_pipe #(.WIDTH(32), .CHUNK(8), .TAG_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (i_flush),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_data   (i_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
`ifdef BITSCAN_PIPE_TAG_EN
    .i_tag    (i_tag),
    .o_tag    (o_tag),
`endif
    .o_zero   (o_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ref_res(input logic [1:0] op, input logic [31:0] d);
    int r;
    r = 0;
    case (op)
      2'd0: r = $countones(d);
      2'd1: for (int i = 0; i < 32; i++) if (d[i]) r = i + 1;
      2'd2: while (r < 32 && d[r]) r++;
      default: for (int i = 31; i >= 0; i--) if (d[i]) r = i + 1;
    endcase
    return 6'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d,
                       input logic rdy, input logic fl, input logic [3:0] tg);
    i_valid = v;
    i_op    = op;
    i_data  = d;
    i_ready = rdy;
    i_flush = fl;
`ifdef BITSCAN_PIPE_TAG_EN
    i_tag   = tg;
`else
    if (tg == 4'hF) i_op = op;
`endif
  endtask

  // One cycle against the scoreboard: the pipe holds at most two requests.
  task automatic cyc(input logic v, input logic [1:0] op, input logic [31:0] d,
                     input logic rdy, input logic fl, input logic [3:0] tg);
    exp_t e;
    logic took;
    drive(v, op, d, rdy, fl, tg);
    #1;
    chk("o_ready", 32'(o_ready), 32'(fl ? 1'b0 : !(q.size() >= 2 && !rdy)));
    if (q.size() == 0) chk("idle_valid", 32'(o_valid), 32'd0);
    if (hold_pend) begin
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_result", 32'(o_result), 32'(hold_res));
      chk("hold_zero", 32'(o_zero), 32'(hold_zero));
`ifdef BITSCAN_PIPE_TAG_EN
      chk("hold_tag", 32'(o_tag), 32'(hold_tag));
`endif
    end
    took = v && o_ready;
    if (o_valid && rdy && !fl && q.size() > 0) begin
      e = q.pop_front();
      chk("result", 32'(o_result), 32'(e.res));
      chk("zero", 32'(o_zero), 32'(e.zero));
`ifdef BITSCAN_PIPE_TAG_EN
      chk("tag", 32'(o_tag), 32'(e.tag));
`endif
    end
    hold_pend = o_valid && !rdy && !fl;
    hold_res  = o_result;
    hold_zero = o_zero;
`ifdef BITSCAN_PIPE_TAG_EN
    hold_tag  = o_tag;
`endif
    if (fl) q.delete();
    else if (took) begin
      e.res  = ref_res(op, d);
      e.zero = (d == 32'd0);
      e.tag  = tg;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Unstalled single request: o_valid must appear exactly two edges after accept.
  task automatic run_one(input logic [1:0] op, input logic [31:0] d,
                         input logic [5:0] expv, input logic ez);
    drive(1'b1, op, d, 1'b1, 1'b0, 4'h0);
    #1;
    chk("one_ready", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    #1;
    chk("one_lat1", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("one_lat2", 32'(o_valid), 32'd1);
    chk("one_result", 32'(o_result), 32'(expv));
    chk("one_zero", 32'(o_zero), 32'(ez));
    chk("one_model", 32'(o_result), 32'(ref_res(op, d)));
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  t_op  [14] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3,
                              2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd2};
  logic [31:0] t_dat [14] = '{32'hF0F0_0001, 32'h0, 32'h0001_0000, 32'h8000_0001,
                              32'h8000_0000, 32'h0000_0100, 32'h0, 32'h0,
                              32'h0000_00FF, 32'h0000_01FF, 32'hFFFF_FFFF, 32'h0000_00FE,
                              32'hFFFF_FFFF, 32'h0};
  logic [5:0]  t_exp [14] = '{6'd9, 6'd0, 6'd17, 6'd32, 6'd32, 6'd9, 6'd0, 6'd0,
                              6'd8, 6'd9, 6'd32, 6'd0, 6'd32, 6'd0};

  initial begin
    logic [31:0] d;
    logic [31:0] sh;
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_result", 32'(o_result), 32'd0);
    chk("rst_zero", 32'(o_zero), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
`ifdef BITSCAN_PIPE_TAG_EN
    chk("rst_tag", 32'(o_tag), 32'd0);
`endif
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) run_one(t_op[i], t_dat[i], t_exp[i], t_dat[i] == 32'd0);

    // Four back-to-back requests against three stalled cycles.
    cyc(1'b1, 2'd0, 32'hF0F0_0001, 1'b0, 1'b0, 4'h3);
    cyc(1'b1, 2'd1, 32'h0001_0000, 1'b0, 1'b0, 4'hA);
    cyc(1'b1, 2'd2, 32'h0000_01FF, 1'b0, 1'b0, 4'h5);
    chk("bp_ready_low", 32'(q.size()), 32'd2);
    cyc(1'b1, 2'd2, 32'h0000_01FF, 1'b1, 1'b0, 4'h5);
    cyc(1'b1, 2'd3, 32'h0000_0100, 1'b1, 1'b0, 4'h6);
    for (int i = 0; i < 6 && q.size() > 0; i++) cyc(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 4'h0);
    chk("bp_drain", 32'(q.size()), 32'd0);

    // Flush with both stages full and a request waiting.
    cyc(1'b1, 2'd0, 32'h0000_000F, 1'b0, 1'b0, 4'h1);
    cyc(1'b1, 2'd0, 32'h0000_00FF, 1'b0, 1'b0, 4'h2);
    cyc(1'b1, 2'd0, 32'h0000_0FFF, 1'b1, 1'b1, 4'h4);
    chk("flush_valid", 32'(o_valid), 32'd0);
    run_one(2'd1, 32'h0000_0400, 6'd11, 1'b0);

    // Reset with requests in flight.
    cyc(1'b1, 2'd0, 32'h1234_5678, 1'b0, 1'b0, 4'h7);
    cyc(1'b1, 2'd0, 32'hFFFF_0000, 1'b0, 1'b0, 4'h8);
    rst = 1'b0;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    hold_pend = 1'b0;
    #1;
    chk("rst2_valid", 32'(o_valid), 32'd0);
    chk("rst2_result", 32'(o_result), 32'd0);
    chk("rst2_zero", 32'(o_zero), 32'd0);

    // Random traffic, stalls and occasional flushes.
    for (int n = 0; n < 600; n++) begin
      sh = 32'($urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0: d = 32'd0;
        1: d = 32'hFFFF_FFFF;
        2: d = (32'd1 << sh) - 32'd1;
        3: d = 32'd1 << sh;
        4: d = ~(32'd1 << sh);
        default: d = $urandom;
      endcase
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), d,
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0),
          4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 6 && q.size() > 0; i++) cyc(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 4'h0);
    chk("rand_drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitscan_pipe.md
Name: bitscan_pipe

Overview:
- Pipelined, parametrised bit-scan unit.
- Computes popcount, highest-set index+1, trailing-ones run length and lowest-set index+1 on a WIDTH-bit operand, selected per request.
- Two-stage valid/ready pipeline with full backpressure and flush.
- Serves rename/dispatch and issue logic that today uses combinational scan helpers on wide masks, where timing no longer closes in one cycle.

Parameters:
- WIDTH, 32, operand width; must be a multiple of CHUNK; max 256.
- CHUNK, 8, bits reduced per stage-1 slice; power of two, 2..WIDTH.
- RES_W, $clog2(WIDTH+1), result width (derived, not overridable).
- TAG_W, 4, tag width (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- i_flush  in  1  drop all in-flight requests.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request.
- i_op  in  2  op select: 0 POPCNT, 1 LAST_IDX, 2 CONT_ONE, 3 FIRST_IDX.
- i_data  in  WIDTH  operand.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_result  out  RES_W  result.
- o_zero  out  1  operand was all zeros.

Behaviour:
- Reset (rst==0 at posedge): s1_valid=0, s2_valid=0, o_result=0, o_zero=0; o_ready=1 from the first cycle after reset. Reset mid-operation discards everything in flight.
- Ops:
  - POPCNT = number of set bits.
  - LAST_IDX = index of the highest set bit + 1; 0 if none.
  - CONT_ONE = count of consecutive ones from bit 0; WIDTH if all ones.
  - FIRST_IDX = index of the lowest set bit + 1; 0 if none.
- Results are zero-extended to RES_W; no overflow is possible.
- Stage 1 (on accept, i_valid & o_ready): per CHUNK slice, register popcount, local hi index+1, local lo index+1, local trailing-ones count and an all-ones flag. Also register op and the zero flag.
- Stage 2: combine slices.
  - POPCNT = sum of slice counts.
  - LAST_IDX = highest slice with nonzero hi, plus slice*CHUNK.
  - FIRST_IDX = lowest slice with nonzero lo, plus slice*CHUNK.
  - CONT_ONE = CHUNK*k + trailing count of slice k, where k is the first slice without the all-ones flag.
- Latency: exactly 2 cycles from accept to o_valid with no stall. Throughput 1/cycle.
- Handshake:
  - s2_adv = !s2_valid | i_ready.
  - s1_adv = !s1_valid | s2_adv.
  - o_ready = s1_adv.
  - o_ready must not depend combinationally on i_valid.
  - o_valid=s2_valid.
  - While o_valid & !i_ready, o_result and o_zero hold stable.
- Ordering: strictly in order; no drop or duplication under any stall pattern.
- Flush: i_flush=1 clears s1_valid and s2_valid at the next edge. A request presented in the same cycle is not accepted (o_ready is forced to 0 while i_flush=1). Flush has priority over output handshake. Data registers may keep stale values.
- Simultaneous output accept and input accept with both stages full: the pipeline shifts and the result is consumed in the same cycle.

Optional Feature:
- Macro BITSCAN_PIPE_TAG_EN.
- Defined: adds ports i_tag (in, TAG_W) and o_tag (out, TAG_W). The tag travels with its request through both stages and appears with o_result. o_tag resets to 0 and obeys the same hold-stable rule.
- Undefined: no tag ports and no tag registers.

Decomposition:
- Package bitscan_pkg:
  - op enum bitscan_op_t (POPCNT, LAST_IDX, CONT_ONE, FIRST_IDX).
  - Per-slice struct slice_info_t {cnt, hi, lo, tr, all1}.
  - Parametrised scan functions generalised from the existing 32-bit helpers to arbitrary width.
- Sub-module bitscan_chunk: combinational, CHUNK bits in, slice_info_t out. Instantiated WIDTH/CHUNK times in stage 1.

Test Plan (WIDTH=32, CHUNK=8):
- POPCNT 0xF0F0_0001 -> 9, o_zero=0. POPCNT 0 -> 0, o_zero=1. o_valid rises exactly 2 cycles after accept.
- LAST_IDX 0x0001_0000 -> 17. LAST_IDX 0x8000_0001 -> 32. FIRST_IDX 0x8000_0000 -> 32. FIRST_IDX 0x0000_0100 -> 9. Both ops on 0 -> 0.
- CONT_ONE 0x0000_00FF -> 8. CONT_ONE 0x0000_01FF -> 9 (crosses slice). CONT_ONE 0xFFFF_FFFF -> 32. CONT_ONE 0x0000_00FE -> 0.
- Backpressure: 4 back-to-back requests, i_ready=0 for 3 cycles.
  - o_ready drops after 2 accepts.
  - o_result stays stable while stalled.
  - All 4 results arrive in order with no loss.
- Flush with both stages full and i_valid=1: o_ready=0 that cycle, then o_valid=0 next cycle. A new request after flush returns its result in 2 cycles.
- Reset asserted with requests in flight: next cycle o_valid=0 and o_result=0. With BITSCAN_PIPE_TAG_EN, tags 0x3 and 0xA return paired with their results.
